// File: rtl/axis_egress_arb_if.sv
// axis_egress_arb_if: per-port source streams plus the merged OPED-bound stream.
// master is the arbiter's view, slave is the view of the surrounding sources/sink.
interface axis_egress_arb_if #(
  parameter int NPORT = 4
) ();
  logic [NPORT*256-1:0] S_AXIS_DAT_TDATA;
  logic [NPORT*32-1:0]  S_AXIS_DAT_TSTRB;
  logic [NPORT-1:0]     S_AXIS_DAT_TVALID;
  logic [NPORT-1:0]     S_AXIS_DAT_TLAST;
  logic [NPORT-1:0]     S_AXIS_DAT_TREADY;
  logic [NPORT*16-1:0]  S_AXIS_LEN_TDATA;
  logic [NPORT*8-1:0]   S_AXIS_SPT_TDATA;
  logic [NPORT*8-1:0]   S_AXIS_DPT_TDATA;
  logic [NPORT-1:0]     S_AXIS_ERR_TDATA;
  logic [255:0]         M_AXIS_DAT_TDATA;
  logic [31:0]          M_AXIS_DAT_TSTRB;
  logic                 M_AXIS_DAT_TVALID;
  logic                 M_AXIS_DAT_TLAST;
  logic                 M_AXIS_DAT_TREADY;
  logic [15:0]          M_AXIS_LEN_TDATA;
  logic [7:0]           M_AXIS_SPT_TDATA;
  logic [7:0]           M_AXIS_DPT_TDATA;
  logic                 M_AXIS_ERR_TDATA;
  modport master (
    input  S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TVALID, S_AXIS_DAT_TLAST,
    input  S_AXIS_LEN_TDATA, S_AXIS_SPT_TDATA, S_AXIS_DPT_TDATA, S_AXIS_ERR_TDATA,
    output S_AXIS_DAT_TREADY,
    output M_AXIS_DAT_TDATA, M_AXIS_DAT_TSTRB, M_AXIS_DAT_TVALID, M_AXIS_DAT_TLAST,
    output M_AXIS_LEN_TDATA, M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA, M_AXIS_ERR_TDATA,
    input  M_AXIS_DAT_TREADY
  );
  modport slave (
    output S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TVALID, S_AXIS_DAT_TLAST,
    output S_AXIS_LEN_TDATA, S_AXIS_SPT_TDATA, S_AXIS_DPT_TDATA, S_AXIS_ERR_TDATA,
    input  S_AXIS_DAT_TREADY,
    input  M_AXIS_DAT_TDATA, M_AXIS_DAT_TSTRB, M_AXIS_DAT_TVALID, M_AXIS_DAT_TLAST,
    input  M_AXIS_LEN_TDATA, M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA, M_AXIS_ERR_TDATA,
    output M_AXIS_DAT_TREADY
  );
endinterface

// File: rtl/axis_egress_arb.sv
// axis_egress_arb: packet-granular round-robin arbiter merging NPORT sources onto the OPED stream.
// A grant is held through TLAST so sideband stays coherent; one idle cycle separates packets.
module axis_egress_arb #(
  parameter int NPORT = 4,
  parameter int CW = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NPORT-1:0]  PORT_EN,
  axis_egress_arb_if.master bus,
  output logic [NPORT-1:0]  GRANT,
  output logic              BUSY,
  output logic [CW-1:0]     PKT_COUNT
);
  localparam int LW = $clog2(NPORT);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] gnt_q, gnt_d, last_q, last_d, sel, j;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NPORT-1:0] req;
  logic [255:0] dat [NPORT];
  logic [31:0] strb [NPORT];
  logic [15:0] len [NPORT];
  logic [7:0] spt [NPORT];
  logic [7:0] dpt [NPORT];
  for (genvar i = 0; i < NPORT; i++) begin : g_unpack
    assign dat[i]  = bus.S_AXIS_DAT_TDATA[i*256 +: 256];
    assign strb[i] = bus.S_AXIS_DAT_TSTRB[i*32 +: 32];
    assign len[i]  = bus.S_AXIS_LEN_TDATA[i*16 +: 16];
    assign spt[i]  = bus.S_AXIS_SPT_TDATA[i*8 +: 8];
    assign dpt[i]  = bus.S_AXIS_DPT_TDATA[i*8 +: 8];
  end
  assign req = bus.S_AXIS_DAT_TVALID & PORT_EN;
  assign BUSY = state_q == PKT;
  assign GRANT = BUSY ? (NPORT'(1) << gnt_q) : '0;
  assign PKT_COUNT = cnt_q;
  assign bus.S_AXIS_DAT_TREADY = GRANT & {NPORT{bus.M_AXIS_DAT_TREADY}};
  assign bus.M_AXIS_DAT_TVALID = BUSY & bus.S_AXIS_DAT_TVALID[gnt_q];
  assign bus.M_AXIS_DAT_TLAST  = BUSY & bus.S_AXIS_DAT_TLAST[gnt_q];
  assign bus.M_AXIS_ERR_TDATA  = BUSY & bus.S_AXIS_ERR_TDATA[gnt_q];
  assign bus.M_AXIS_DAT_TDATA  = BUSY ? dat[gnt_q] : '0;
  assign bus.M_AXIS_DAT_TSTRB  = BUSY ? strb[gnt_q] : '0;
  assign bus.M_AXIS_LEN_TDATA  = BUSY ? len[gnt_q] : '0;
  assign bus.M_AXIS_SPT_TDATA  = BUSY ? spt[gnt_q] : '0;
  assign bus.M_AXIS_DPT_TDATA  = BUSY ? dpt[gnt_q] : '0;
  // Scan from farthest to nearest so the port closest after last_q wins.
  always_comb begin
    j = '0;
    sel = last_q;
    for (int k = NPORT; k >= 1; k--) begin
      j = LW'((int'(last_q) + k) % NPORT);
      sel = req[j] ? j : sel;
    end
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (!BUSY && |req) begin
      state_d = PKT;
      gnt_d = sel;
    end
    if (bus.M_AXIS_DAT_TVALID && bus.M_AXIS_DAT_TREADY && bus.M_AXIS_DAT_TLAST) begin
      state_d = IDLE;
      last_d = gnt_q;
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= LW'(NPORT - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axis_egress_arb.sv
// tb_axis_egress_arb: randomized sources against a packet-level round-robin model.
// Expected beats are queued when packets are loaded; a monitor pops them on each accepted M beat.
module tb_axis_egress_arb;
  localparam int NPORT = 4;
  localparam int CW = 32;
  logic ACLK = 1'b0;
  logic ARESET;
  logic [NPORT-1:0] PORT_EN;
  logic [NPORT-1:0] GRANT;
  logic BUSY;
  logic [CW-1:0] PKT_COUNT;
  axis_egress_arb_if #(.NPORT(NPORT)) bus ();
  axis_egress_arb #(.NPORT(NPORT), .CW(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .PORT_EN(PORT_EN), .bus(bus.master),
    .GRANT(GRANT), .BUSY(BUSY), .PKT_COUNT(PKT_COUNT)
  );
  always #5 ACLK = ~ACLK;
  typedef struct packed {
    logic [255:0] d;
    logic [31:0] s;
    logic l;
    logic [15:0] len;
    logic [7:0] spt;
    logic [7:0] dpt;
    logic e;
    logic f;
  } beat_t;
  beat_t src_q[NPORT][$];
  beat_t mq[NPORT][$];
  logic [335:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_last = NPORT - 1;
  logic [CW-1:0] m_cnt = '0;
  bit gaps = 0, rnd_rdy = 0, mon_en = 0;
  task automatic chk(input string nm, input logic [335:0] act, input logic [335:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  function automatic logic [335:0] pack(input beat_t b, input int p);
    logic [NPORT-1:0] g;
    g = NPORT'(1 << p);
    return {10'b0, b.d, b.s, b.l, b.len, b.spt, b.dpt, b.e, g};
  endfunction
  task automatic add_pkt(input int p, input int n, input bit rnd);
    beat_t b;
    logic [7:0] dpt;
    dpt = rnd ? 8'($urandom) : 8'd5;
    for (int k = 0; k < n; k++) begin
      b.d = rnd ? {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}
                : 256'(8'hA1 + k);
      b.s = rnd ? $urandom : '1;
      b.l = (k == n - 1);
      b.len = 16'(n * 32);
      b.spt = 8'(p);
      b.dpt = dpt;
      b.e = rnd && b.l && ($urandom_range(0, 1) == 1);
      b.f = (k == 0);
      src_q[p].push_back(b);
      mq[p].push_back(b);
    end
  endtask
  // Whole-packet round robin over the ports that still hold packets.
  task automatic plan(input logic [NPORT-1:0] mask);
    int p;
    beat_t b;
    do begin
      p = -1;
      for (int k = 1; k <= NPORT; k++) begin
        int q = (m_last + k) % NPORT;
        if (mask[q] && mq[q].size() > 0) begin
          p = q;
          break;
        end
      end
      if (p >= 0) begin
        do begin
          b = mq[p].pop_front();
          exp_q.push_back(pack(b, p));
        end while (!b.l);
        m_last = p;
        m_cnt++;
      end
    end while (p >= 0);
  endtask
  task automatic drive();
    for (int i = 0; i < NPORT; i++) begin
      beat_t b;
      logic v;
      b = '0;
      v = 1'b0;
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        v = b.f || !gaps || ($urandom_range(0, 3) != 0);
      end
      bus.S_AXIS_DAT_TDATA[i*256 +: 256] = b.d;
      bus.S_AXIS_DAT_TSTRB[i*32 +: 32] = b.s;
      bus.S_AXIS_DAT_TVALID[i] = v;
      bus.S_AXIS_DAT_TLAST[i] = b.l;
      bus.S_AXIS_LEN_TDATA[i*16 +: 16] = b.len;
      bus.S_AXIS_SPT_TDATA[i*8 +: 8] = b.spt;
      bus.S_AXIS_DPT_TDATA[i*8 +: 8] = b.dpt;
      bus.S_AXIS_ERR_TDATA[i] = b.e;
    end
    bus.M_AXIS_DAT_TREADY = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge ACLK);
      #2;
      if (exp_q.size() == 0 && !BUSY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: timeout with %0d beats outstanding, want 0", exp_q.size());
    end
  endtask
  task automatic do_reset();
    mon_en = 0;
    ARESET = 1'b1;
    for (int i = 0; i < NPORT; i++) begin
      src_q[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    m_last = NPORT - 1;
    m_cnt = '0;
    drive();
    #1;
    chk("rst_grant", GRANT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_count", PKT_COUNT, 0);
    chk("rst_mvalid", bus.M_AXIS_DAT_TVALID, 0);
    chk("rst_mdata", bus.M_AXIS_DAT_TDATA, 0);
    repeat (2) @(posedge ACLK);
    #2;
    ARESET = 1'b0;
    mon_en = 1;
  endtask
  task automatic wait_grant0();
    bit seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge ACLK);
      #2;
      if (GRANT[0]) begin
        seen = 1;
        break;
      end
    end
    chk("grant0_seen", seen, 1);
  endtask
  initial begin
    bit fire[NPORT];
    forever begin
      @(negedge ACLK);
      for (int i = 0; i < NPORT; i++) fire[i] = bus.S_AXIS_DAT_TVALID[i] & bus.S_AXIS_DAT_TREADY[i];
      @(posedge ACLK);
      #1;
      for (int i = 0; i < NPORT; i++) if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive();
    end
  end
  initial begin
    logic [255:0] held;
    logic [NPORT-1:0] g;
    bit stall = 0;
    forever begin
      @(negedge ACLK);
      if (!mon_en) begin
        stall = 0;
        continue;
      end
      g = exp_q.size() > 0 ? exp_q[0][NPORT-1:0] : '0;
      if (BUSY) begin
        chk("grant", GRANT, g);
        chk("s_tready", bus.S_AXIS_DAT_TREADY, bus.M_AXIS_DAT_TREADY ? g : '0);
      end else begin
        chk("idle_outputs", {GRANT, bus.S_AXIS_DAT_TREADY, bus.M_AXIS_DAT_TVALID, bus.M_AXIS_DAT_TDATA}, 0);
      end
      if (stall && bus.M_AXIS_DAT_TVALID) chk("stall_hold", bus.M_AXIS_DAT_TDATA, held);
      stall = bus.M_AXIS_DAT_TVALID && !bus.M_AXIS_DAT_TREADY;
      held = bus.M_AXIS_DAT_TDATA;
      if (bus.M_AXIS_DAT_TVALID && bus.M_AXIS_DAT_TREADY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat: got unexpected beat %0h want none", bus.M_AXIS_DAT_TDATA);
        end else begin
          chk("beat", {10'b0, bus.M_AXIS_DAT_TDATA, bus.M_AXIS_DAT_TSTRB, bus.M_AXIS_DAT_TLAST,
                       bus.M_AXIS_LEN_TDATA, bus.M_AXIS_SPT_TDATA, bus.M_AXIS_DPT_TDATA,
                       bus.M_AXIS_ERR_TDATA, GRANT}, exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    PORT_EN = '1;
    do_reset();
    add_pkt(2, 3, 0);
    plan('1);
    @(posedge ACLK);
    #2;
    chk("t1_bubble", bus.M_AXIS_DAT_TVALID, 0);
    @(posedge ACLK);
    #2;
    chk("t1_first_beat", {GRANT, bus.M_AXIS_DAT_TVALID, bus.M_AXIS_DAT_TDATA}, {4'b0100, 1'b1, 256'hA1});
    wait_done();
    chk("t1_count", PKT_COUNT, 1);
    do_reset();
    for (int r = 0; r < 2; r++) for (int p = 0; p < NPORT; p++) add_pkt(p, 2, 1);
    plan('1);
    @(posedge ACLK);
    repeat (23) @(posedge ACLK);
    #2;
    chk("t2_count_23", PKT_COUNT, 7);
    @(posedge ACLK);
    #2;
    chk("t2_count_24", PKT_COUNT, 8);
    wait_done();
    rnd_rdy = 1;
    gaps = 1;
    add_pkt(1, 4, 1);
    add_pkt(3, 2, 1);
    plan('1);
    wait_done();
    chk("t3_count", PKT_COUNT, m_cnt);
    PORT_EN = 4'b1101;
    add_pkt(0, 4, 1);
    add_pkt(1, 2, 1);
    add_pkt(2, 3, 1);
    add_pkt(2, 1, 1);
    add_pkt(3, 2, 1);
    plan(4'b1101);
    wait_grant0();
    PORT_EN[0] = 1'b0;
    chk("t4_busy_after_en_drop", BUSY, 1);
    wait_done();
    chk("t4_count", PKT_COUNT, m_cnt);
    src_q[1].delete();
    mq[1].delete();
    @(posedge ACLK);
    #2;
    PORT_EN = '1;
    rnd_rdy = 0;
    gaps = 0;
    add_pkt(0, 4, 1);
    plan('1);
    wait_grant0();
    @(posedge ACLK);
    #2;
    chk("t5_mid_packet", bus.M_AXIS_DAT_TVALID, 1);
    mon_en = 0;
    ARESET = 1'b1;
    #1;
    chk("t5_async_mvalid", bus.M_AXIS_DAT_TVALID, 0);
    chk("t5_async_grant", GRANT, 0);
    chk("t5_async_count", PKT_COUNT, 0);
    do_reset();
    add_pkt(2, 2, 1);
    add_pkt(0, 2, 1);
    plan('1);
    @(posedge ACLK);
    @(posedge ACLK);
    #2;
    chk("t5_port0_first", GRANT, 4'b0001);
    wait_done();
    chk("t5_count", PKT_COUNT, m_cnt);
    rnd_rdy = 1;
    gaps = 1;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < NPORT; p++) repeat ($urandom_range(0, 3)) add_pkt(p, $urandom_range(1, 5), 1);
      plan('1);
      wait_done();
      chk("rnd_count", PKT_COUNT, m_cnt);
    end
    @(posedge ACLK);
    #2;
    force dut.cnt_q = '1;
    #1;
    release dut.cnt_q;
    add_pkt(1, 1, 1);
    plan('1);
    wait_done();
    chk("wrap_count", PKT_COUNT, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axis_egress_arb.md
Name: axis_egress_arb

Overview:
- Packet-granular round-robin arbiter that shares the single OPED ingress stream (S_AXIS_DAT_* plus LEN/SPT/DPT/ERR sideband) among NPORT data-plane sources.
- Sits between the data-plane cores and OPED, in place of a single loopback feeding OPED directly.
- Holds a grant for a whole packet (through TLAST) so the sideband stays coherent, and counts forwarded packets for control-plane visibility.

Parameters:
- NPORT, 4, number of requesting source ports (2..8).
- CW, 32, width of forwarded-packet counter.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- PORT_EN  in  NPORT  per-port arbitration enable; sampled only in IDLE.
- S_AXIS_DAT_TDATA  in  NPORT*256  source data, port i at [256i+255:256i].
- S_AXIS_DAT_TSTRB  in  NPORT*32  source byte strobes.
- S_AXIS_DAT_TVALID  in  NPORT  source valid.
- S_AXIS_DAT_TLAST  in  NPORT  source end of packet.
- S_AXIS_DAT_TREADY  out  NPORT  source ready.
- S_AXIS_LEN_TDATA  in  NPORT*16  packet byte length sideband.
- S_AXIS_SPT_TDATA  in  NPORT*8  source-port sideband.
- S_AXIS_DPT_TDATA  in  NPORT*8  destination-port sideband.
- S_AXIS_ERR_TDATA  in  NPORT  error sideband.
- M_AXIS_DAT_TDATA  out  256  merged data to OPED.
- M_AXIS_DAT_TSTRB  out  32  merged strobes.
- M_AXIS_DAT_TVALID  out  1  merged valid.
- M_AXIS_DAT_TLAST  out  1  merged last.
- M_AXIS_DAT_TREADY  in  1  OPED ready.
- M_AXIS_LEN_TDATA  out  16  merged length sideband.
- M_AXIS_SPT_TDATA  out  8  merged source-port sideband.
- M_AXIS_DPT_TDATA  out  8  merged destination-port sideband.
- M_AXIS_ERR_TDATA  out  1  merged error sideband.
- GRANT  out  NPORT  one-hot current grant; all zero when idle.
- BUSY  out  1  high while a packet is in flight.
- PKT_COUNT  out  CW  packets forwarded since reset.

Behaviour:
- Reset (async, ARESET=1):
  - State IDLE; GRANT=0; BUSY=0; PKT_COUNT=0.
  - Last-served pointer = NPORT-1, so port 0 has first priority.
  - All S_TREADY=0; M_TVALID=0.
  - M data/sideband outputs are 0. They are combinational from state, so they clear immediately on reset.
- States: IDLE and PKT.
- IDLE:
  - Request vector req[i] = S_TVALID[i] & PORT_EN[i].
  - If req≠0, select the first requesting port searching last+1, last+2, … with modulo NPORT wrap.
  - Register that port into GRANT and move to PKT on the next edge.
  - If req=0, stay in IDLE.
  - All S_TREADY=0, M_TVALID=0, M outputs 0 while in IDLE.
- PKT (granted port g):
  - Combinational pass-through from port g: M_TDATA/TSTRB/TLAST/TVALID and LEN/SPT/DPT/ERR are driven from port g's inputs.
  - S_TREADY[g] = M_TREADY; all other S_TREADY = 0.
  - A beat is accepted when M_TVALID & M_TREADY.
  - On an accepted beat with TLAST=1:
    - Next state IDLE; last-served pointer = g; GRANT=0.
    - PKT_COUNT += 1, wrapping from 2^CW-1 to 0.
  - Accepted beats without TLAST leave the state unchanged.
  - Source deasserting TVALID mid-packet: M_TVALID follows it low; grant is held, no timeout.
  - PORT_EN[g] falling mid-packet: ignored; the packet completes.
- Latency: one-cycle arbitration bubble between packets.
  - First beat of a packet appears on M one cycle after the request is seen in IDLE.
  - Back-to-back packets therefore have a minimum one idle cycle between them.
  - Zero added latency per beat within a packet.
- BUSY = (state==PKT).
- Single-beat packet (TVALID & TLAST on its first beat, TREADY=1): completes in one PKT cycle.
- Requests from non-granted ports are held off (TREADY=0). A late request never preempts the current packet.
- Reset asserted mid-packet: the packet is truncated on M; no recovery is attempted. Upstream sources are reset by the same ARESET.

Test Plan:
- Reset, then a single packet from port 2 (3 beats, TDATA=0x…A1/A2/A3, LEN=96, SPT=2, DPT=5), M_TREADY=1:
  - M shows the 3 beats starting the cycle after TVALID, with TLAST on beat 3 and sideband 96/2/5.
  - PKT_COUNT=1; GRANT=0b0100 during the packet.
- All 4 ports hold 2-beat packets continuously, PORT_EN=0xF:
  - Grant order is 0,1,2,3,0,…
  - Each packet is 2 beats followed by 1 idle cycle.
  - PKT_COUNT=8 after 24 cycles.
- Port 1 packet in flight, M_TREADY toggling 1,0,0,1 with port 3 also requesting:
  - Port 1 data holds stable while stalled.
  - S_TREADY[3]=0 until port 1's TLAST is accepted; then port 3 is granted.
- PORT_EN=0b1101 with all ports requesting:
  - Port 1 is never granted; order is 0,2,3,0.
  - Clearing PORT_EN[0] mid-packet does not cut that packet short.
- ARESET pulsed during beat 2 of a 4-beat packet:
  - Immediately M_TVALID=0, GRANT=0, PKT_COUNT=0.
  - After release with port 0 requesting, port 0 is granted first.
- Preload PKT_COUNT to 0xFFFFFFFF via force, then complete one packet:
  - PKT_COUNT=0x00000000.
